// File: rtl/write_buffer.sv
// write_buffer: posted-store FIFO feeding the arbiter write-back port, with coalescing and load forwarding
//   CLK, RESET                 clock, synchronous active-high reset
//   st_req/st_addr/st_data     store from data cache; st_stall asks it to hold and retry
//   lk_addr -> lk_hit/lk_data  combinational load-after-store lookup (youngest match)
//   wb_empty                   nothing queued and no write outstanding
//   WB_req/WB_addr/WB_data     head entry offered to the arbiter; WB_granted pops it
//   WB_full                    all entries occupied
module write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 23,
  parameter int DW    = 32
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          st_req,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  output logic          st_stall,
  input  logic [AW-1:0] lk_addr,
  output logic          lk_hit,
  output logic [DW-1:0] lk_data,
  output logic          wb_empty,
  output logic          WB_req,
  output logic [AW-1:0] WB_addr,
  output logic [DW-1:0] WB_data,
  output logic          WB_full,
  input  logic          WB_granted
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
  state_t state_q, state_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, j, match_idx;
  logic [PW:0] count_q, count_d;
  logic match, push, pop;
  assign WB_req   = state_q == REQ;
  assign WB_addr  = addr_q[head_q];
  assign WB_data  = data_q[head_q];
  assign WB_full  = count_q == FULL;
  assign wb_empty = (count_q == '0) && !WB_req;
  assign st_stall = st_req & WB_full & ~match;
  assign push     = st_req & ~match & ~WB_full;
  assign pop      = WB_req & WB_granted;
  // Scan oldest to youngest so the last hit is the youngest; the head being
  // offered to the arbiter is frozen and never takes a coalescing store.
  always_comb begin
    match = 1'b0;
    match_idx = '0;
    lk_hit = 1'b0;
    lk_data = '0;
    j = '0;
    for (int k = 0; k < DEPTH; k++) begin
      j = head_q + PW'(k);
      if (valid_q[j] && addr_q[j] == st_addr && !(j == head_q && WB_req)) begin
        match = 1'b1;
        match_idx = j;
      end
      if (valid_q[j] && addr_q[j] == lk_addr) begin
        lk_hit = 1'b1;
        lk_data = data_q[j];
      end
    end
  end
  always_comb begin
    valid_d = valid_q;
    addr_d = addr_q;
    data_d = data_q;
    head_d = head_q;
    tail_d = tail_q;
    if (st_req && match) data_d[match_idx] = st_data;
    if (push) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q] = st_addr;
      data_d[tail_q] = st_data;
      tail_d = tail_q + PW'(1);
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d = head_q + PW'(1);
    end
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    // GAP drops WB_req for one cycle so the arbiter sees a fresh rising edge
    state_d = state_q == REQ ? (WB_granted ? GAP : REQ) : (count_q != '0 ? REQ : IDLE);
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      valid_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge CLK) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end
endmodule
